// File: rtl/alu_seq.sv
// Sequential multiply/divide unit: shift-add MUL, restoring DIVU/REMU (signed DIV/REM with ALU_SEQ_SIGNED_EN).
// Latency: MUL 33 cycles, divide 65 (66 signed), zero divisor 1 cycle from accept to resp_valid.
// Backpressure: single request in flight; req_ready only in IDLE, result held in DONE until resp_ready.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_less,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [3:0] CTR_ADD = 4'b0000;
    localparam logic [3:0] CTR_SUB = 4'b1000;
    localparam logic [3:0] CTR_LTU = 4'b1011;

    typedef enum logic [2:0] {
        IDLE,
        MUL_STEP,
        DIV_CMP,
        DIV_SUB,
        DONE
`ifdef ALU_SEQ_SIGNED_EN
        , FIX
`endif
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] acc;      // running product
    logic [WIDTH-1:0] mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier;   // multiplier, shifted right each step
    logic [WIDTH-1:0] dvd;      // dividend, shifted left so the next bit is at the MSB
    logic [WIDTH-1:0] dvs;      // divisor
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] quo;      // quotient bits collected MSB first
    logic [WIDTH-1:0] res;      // result presented in DONE
    logic [CW-1:0]    cnt;      // step / iteration counter
    logic             lt;       // shifted remainder below divisor
    logic             want_rem;

    logic             is_mul;
    logic             is_rem;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

`ifdef ALU_SEQ_SIGNED_EN
    logic             is_sgn;
    logic             sgn_op;   // operation needs the sign fix-up cycle
    logic             neg_res;  // fix-up negates the unsigned result

    assign is_sgn = (req_op == 3'b011) || (req_op == 3'b100);
    assign a_mag  = (is_sgn && req_a[WIDTH-1]) ? -req_a : req_a;
    assign b_mag  = (is_sgn && req_b[WIDTH-1]) ? -req_b : req_b;
`else
    assign a_mag  = req_a;
    assign b_mag  = req_b;
`endif

    // Op decode: 001/011 quotient, 010/100 remainder, everything else multiplies.
    always_comb begin
        is_mul = 1'b0;
        is_rem = 1'b0;
        case (req_op)
            3'b001, 3'b011: is_mul = 1'b0;
            3'b010, 3'b100: is_rem = 1'b1;
            default:        is_mul = 1'b1;
        endcase
    end

    // The ALU only sees 32 bits of the shifted remainder; a set rem MSB means the true
    // 33-bit value already exceeds any divisor, so lt is forced low and the wrapped
    // subtraction result is still the exact difference.
    assign rem_s   = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    assign rem_nxt = lt ? rem_s : alu_y;
    assign quo_nxt = {quo[WIDTH-2:0], ~lt};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: latch on accept, iterate in the step states.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            res      <= '0;
            cnt      <= '0;
            lt       <= 1'b0;
            want_rem <= 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
            sgn_op   <= 1'b0;
            neg_res  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc      <= '0;
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                        lt       <= 1'b0;
                        mcand    <= req_a;
                        mplier   <= req_b;
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        want_rem <= is_rem;
                        // A zero divisor finishes immediately with all-ones / dividend.
                        if (!is_mul && (req_b == '0)) begin
                            res <= is_rem ? req_a : '1;
                        end else begin
                            res <= '0;
                        end
`ifdef ALU_SEQ_SIGNED_EN
                        sgn_op  <= is_sgn && (req_b != '0);
                        neg_res <= is_rem ? req_a[WIDTH-1]
                                          : (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
`endif
                    end
                end
                MUL_STEP: begin
                    acc    <= alu_y;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        res <= alu_y;
                    end
                end
                DIV_CMP: begin
                    lt <= alu_less & ~rem[WIDTH-1];
                end
                DIV_SUB: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    dvd <= dvd << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        res <= want_rem ? rem_nxt : quo_nxt;
                    end
                end
`ifdef ALU_SEQ_SIGNED_EN
                FIX: begin
                    if (neg_res) begin
                        res <= -res;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and ALU / handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctr    = CTR_ADD;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (is_mul) begin
                        state_nxt = MUL_STEP;
                    end else if (req_b == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIV_CMP;
                    end
                end
            end
            MUL_STEP: begin
                alu_a   = acc;
                alu_b   = mplier[0] ? mcand : '0;
                alu_ctr = CTR_ADD;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DIV_CMP: begin
                alu_a     = rem_s;
                alu_b     = dvs;
                alu_ctr   = CTR_LTU;
                state_nxt = DIV_SUB;
            end
            DIV_SUB: begin
                alu_a   = rem_s;
                alu_b   = dvs;
                alu_ctr = CTR_SUB;
                if (cnt == LAST) begin
`ifdef ALU_SEQ_SIGNED_EN
                    state_nxt = sgn_op ? FIX : DONE;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = DIV_CMP;
                end
            end
`ifdef ALU_SEQ_SIGNED_EN
            FIX: begin
                state_nxt = DONE;
            end
`endif
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign resp_data = res;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU plus arithmetic reference model, directed and random ops.
// Latency: measures accept-to-resp_valid cycle count against the expected count per op.
// Backpressure: holds resp_ready low for a few cycles in DONE and checks the held result.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_y;
    logic        alu_less;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctr    (alu_ctr),
        .alu_y      (alu_y),
        .alu_less   (alu_less),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Shared combinational ALU seen by the DUT.
    always_comb begin
        alu_y = 32'd0;
        case (alu_ctr)
            4'b0000: alu_y = alu_a + alu_b;
            4'b1000: alu_y = alu_a - alu_b;
            4'b1011: alu_y = {31'd0, alu_a < alu_b};
            default: alu_y = 32'd0;
        endcase
    end
    assign alu_less = alu_a < alu_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic is_signed_op(input logic [2:0] op);
        logic s;
        s = 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
        s = (op == 3'b011) || (op == 3'b100);
`endif
        return s;
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == 3'b000) || (op > 3'b100);
    endfunction

    // Expected result from plain arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] p;
        sa = a;
        sb = b;
        p  = a * b;
        if (is_mul_op(op)) return p;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!is_signed_op(op)) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return ((op == 3'b010) || (op == 3'b100)) ? r : q;
    endfunction

    // Expected accept-to-resp_valid cycle count.
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
        if (is_mul_op(op)) return 33;
        if (b == 32'd0) return 1;
        return is_signed_op(op) ? 66 : 65;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp_d;
        int          exp_lat;
        int          cyc;
        int          w;
        exp_d   = ref_res(op, a, b);
        exp_lat = ref_lat(op, b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        cyc = 1;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        check({tag, " nordy"}, {31'd0, req_ready}, 32'd0);
        while (!resp_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, " data"}, resp_data, exp_d);
        if (!resp_valid) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
        end
        check({tag, " aluctr"}, {28'd0, alu_ctr}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold data"}, resp_data, exp_d);
            check({tag, " hold rdy"}, {30'd0, req_ready, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
    endtask

    initial begin
        int seen;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst resp_data", resp_data, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst alu_ctr", {28'd0, alu_ctr}, 32'd0);

        // Directed cases
        run_op("mul7x6", 3'b000, 32'd7, 32'd6, 0);
        run_op("mulff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu100_7", 3'b001, 32'd100, 32'd7, 0);
        run_op("remu100_7", 3'b010, 32'd100, 32'd7, 5);
        run_op("divu5_0", 3'b001, 32'd5, 32'd0, 0);
        run_op("remu5_0", 3'b010, 32'd5, 32'd0, 0);
        run_op("div-7_2", 3'b011, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divmin", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("remmin", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_0", 3'b011, 32'hFFFF_FFF0, 32'd0, 0);
        run_op("divu_big", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("remu_big", 3'b010, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_op("op7mul", 3'b111, 32'd12, 32'd11, 0);

        // Reset during a divide aborts it without a response
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b001;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort req_ready", {31'd0, req_ready}, 32'd1);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort resp_data", resp_data, 32'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("abort no resp", 32'(seen), 32'd0);
        run_op("mul3x3", 3'b000, 32'd3, 32'd3, 0);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = 32'd0;
                default: b = $urandom | 32'h8000_0000;
            endcase
            run_op("rand", op, a, b, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
